instr_fetch_decode: RTL

Instruction fetch and decode front end for the master CPU. It reads 32-bit instruction words from the RAM through the RAM's Enable/RW/Address/Out port, keeping its own program counter. It splits each word into the Cond/OpCode/S/destination/source_2/source_1/IV fields and hands them to the register bank, memory_control and MASTER_ALU with a valid/ready handshake. It replaces the bench-driven instruction stream, so the CPU can run a program image held in RAM.

---
 rtl/instr_fetch_decode.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: reads 32-bit words from RAM at its own
// program counter, splits them into fields and issues them over valid/ready.
module instr_fetch_decode #(
  parameter int         PC_W    = 8,
  parameter int         ADDR_W  = 16,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              pc_load,
  input  logic [PC_W-1:0]   pc_target,
  output logic              Enable,
  output logic              RW_ram,
  output logic [ADDR_W-1:0] Address_in,
  input  logic [31:0]       Out,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [3:0]        Cond,
  output logic [3:0]        OpCode,
  output logic              S,
  output logic [3:0]        destination,
  output logic [3:0]        source_2,
  output logic [3:0]        source_1,
  output logic [4:0]        IV,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] fetch_pc;
  logic [25:0]     instr_p1;
  logic            unused_low_bits;

  // The low six bits of the word carry no field and are never stored.
  assign unused_low_bits = ^Out[5:0];

  assign RW_ram     = 1'b0;
  assign Address_in = {{(ADDR_W-PC_W){1'b0}}, fetch_pc};
  assign {Cond, OpCode, S, destination, source_2, source_1, IV} = instr_p1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      fetch_pc    <= '0;
      pc          <= '0;
      instr_p1    <= '0;
      Enable      <= 1'b0;
      issue_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            fetch_pc <= start_addr;
            state    <= S_FETCH;
            Enable   <= 1'b1;
            halted   <= 1'b0;
          end
        end
        // RAM sees the address this cycle; data returns during WAIT.
        S_FETCH: begin
          if (pc_load) begin
            fetch_pc <= pc_target;
            Enable   <= 1'b1;
          end else begin
            state  <= S_WAIT;
            Enable <= 1'b0;
          end
        end
        S_WAIT: begin
          if (pc_load) begin
            fetch_pc <= pc_target;
            state    <= S_FETCH;
            Enable   <= 1'b1;
          end else begin
            instr_p1 <= Out[31:6];
            pc       <= fetch_pc;
            if (Out[27:24] == HALT_OP) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state       <= S_ISSUE;
              issue_valid <= 1'b1;
            end
          end
        end
        // A redirect wins over the sequential next address, handshake or not.
        S_ISSUE: begin
          if (pc_load) begin
            fetch_pc    <= pc_target;
            state       <= S_FETCH;
            Enable      <= 1'b1;
            issue_valid <= 1'b0;
          end else if (issue_ready) begin
            fetch_pc    <= fetch_pc + PC_W'(1);
            state       <= S_FETCH;
            Enable      <= 1'b1;
            issue_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          Enable      <= 1'b0;
          issue_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
